prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Boot-time program loader sitting directly upstream of the single-cycle core (full_cycle).
//  Accepts a byte stream (valid/ready), packs bytes little-endian into 32-bit instruction words,
//  and writes them sequentially into the instruction memory write port.
//  Holds the core in reset (cpu_rst) until the programmed word count has been written, then releases it.
// PARAMETERS
//  ADDR_W     8   instruction memory word-address width (depth = 2**ADDR_W words)
//  BASE_ADDR  0   word address of the first written instruction
// PORTS
//  clk          in   1         system clock, all state on rising edge
//  rst          in   1         asynchronous, active-low reset (0 = reset)
//  start        in   1         one-cycle load request, sampled only in IDLE/RUN
//  word_count   in   ADDR_W+1  number of words to load, sampled with start
//  byte_valid   in   1         byte_data is valid this cycle
//  byte_data    in   8         incoming program byte
//  byte_ready   out  1         loader accepts a byte this cycle
//  imem_we      out  1         instruction memory write enable (one-cycle pulse per word)
//  imem_addr    out  ADDR_W    instruction memory word address
//  imem_wdata   out  32        assembled instruction word
//  cpu_rst      out  1         active-high reset to the core
//  busy         out  1         load in progress (COLLECT or WRITE)
//  done         out  1         one-cycle pulse when the last word has been written
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; cpu_rst=1; byte_ready=0; imem_we=0; imem_addr=BASE_ADDR;
//   imem_wdata=0; busy=0; done=0; byte and word counters=0. Memory contents are not touched.
//  States: IDLE -> COLLECT -> WRITE -> (COLLECT | RUN); RUN -> COLLECT on start.
//  IDLE: cpu_rst=1. On start: latch cnt=min(word_count, 2**ADDR_W); if cnt==0 go RUN with done=1
//   the next cycle; else go COLLECT with word_idx=0, byte_idx=0.
//  COLLECT: byte_ready=1, busy=1, cpu_rst=1. Handshake = byte_valid & byte_ready.
//   Each handshake stores byte_data at bits [8*byte_idx+7 : 8*byte_idx] (first byte = LSB) and
//   increments byte_idx. The 4th handshake moves to WRITE. No handshake -> hold; no timeout.
//  WRITE (exactly one cycle): imem_we=1, imem_addr=BASE_ADDR+word_idx (mod 2**ADDR_W),
//   imem_wdata=assembled word, byte_ready=0. Latency: 4th byte handshake at edge N -> imem_we
//   high during cycle N+1. If word_idx==cnt-1 -> RUN, else word_idx++, byte_idx=0, -> COLLECT.
//  RUN: cpu_rst=0, busy=0, byte_ready=0. done=1 only for the first cycle in RUN.
//   start in RUN re-asserts cpu_rst the next cycle and reloads (same rules as IDLE).
//  start while busy: ignored (count not re-latched). byte_valid outside COLLECT: ignored.
//  Address wrap: BASE_ADDR+word_idx beyond the top wraps to 0; cnt saturates at 2**ADDR_W so no
//   address is written twice within one load.
//  Reset mid-load: immediate return to reset values; partial word discarded; words already
//   written stay in memory; the core remains in reset until a complete load.
//  imem_we is never high in any state other than WRITE; at most one write every 5 cycles.
// TESTING
//  1. rst=0 for 100 ns then release -> cpu_rst=1, byte_ready=0, imem_we=0, state IDLE.
//  2. start, word_count=2, bytes 13 00 50 00 93 00 10 00 back to back -> writes
//     addr0=0x00500013, addr1=0x00100093; done pulse; cpu_rst=0 on the cycle after the last write.
//  3. Same load with byte_valid toggled 1/0 each cycle -> same words/addresses, no extra or
//     lost bytes; byte_ready low during each WRITE cycle.
//  4. start with word_count=0 -> no imem_we, done pulse, cpu_rst=0; start with word_count=300,
//     ADDR_W=8 -> exactly 256 writes, addresses 0..255.
//  5. rst=0 after 2 bytes of word 1 -> outputs back to reset values; new load with count=1
//     -> word assembled only from new bytes.
//  6. In RUN, start with count=1, bytes AA BB CC DD -> cpu_rst=1 the next cycle, write
//     0xDDCCBBAA at BASE_ADDR, then cpu_rst=0; start pulsed during COLLECT ignored.

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time program loader: packs a little-endian byte stream into 32-bit words,
// writes them sequentially into instruction memory and holds the core in reset until done.
module prog_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [ADDR_W:0] word_idx_q, word_idx_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [31:0]     word_q, word_d;
  logic            done_q, done_d;
  logic [ADDR_W:0] load_cnt;

  // Saturating the count at the memory depth guarantees no address is written twice per load.
  assign load_cnt = (word_count > DEPTH) ? DEPTH : word_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE, S_RUN: begin
        if (start) begin
          cnt_d      = load_cnt;
          word_idx_d = '0;
          byte_idx_d = '0;
          if (load_cnt == '0) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (byte_valid) begin
          word_d[8*byte_idx_q +: 8] = byte_data;
          byte_idx_d                = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (word_idx_q == cnt_q - ONE) begin
          state_d = S_RUN;
          done_d  = 1'b1;
        end else begin
          word_idx_d = word_idx_q + ONE;
          byte_idx_d = '0;
          state_d    = S_COLLECT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address wraps naturally by truncating to ADDR_W bits.
  assign imem_addr  = BASE + word_idx_q[ADDR_W-1:0];
  assign imem_wdata = word_q;
  assign imem_we    = (state_q == S_WRITE);
  assign byte_ready = (state_q == S_COLLECT);
  assign busy       = (state_q == S_COLLECT) || (state_q == S_WRITE);
  assign cpu_rst    = (state_q != S_RUN);
  assign done       = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader: a transaction-level model predicts every memory write,
// the done pulse and the core-reset/busy/ready levels, checked on each falling clock edge.
module tb_prog_loader;
  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start = 1'b0;
  logic [8:0]  word_count = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, imem_we, cpu_rst, busy, done;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;

  prog_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  wr_t         exp_q[$];
  logic [7:0]  log_a[$];
  logic [31:0] log_d[$];
  bit          load_active = 0;
  bit          exp_run = 0;
  bit          exp_done_next = 0;
  int          since_wr = 100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_cpu_rst", cpu_rst, 1);
      chk("rst_byte_ready", byte_ready, 0);
      chk("rst_imem_we", imem_we, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_imem_wdata", imem_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      since_wr = 100;
    end else begin
      since_wr++;
      if (exp_done_next) begin
        chk("done_pulse", done, 1);
        exp_run       = 1;
        exp_done_next = 0;
      end else begin
        chk("done_quiet", done, 0);
      end
      chk("cpu_rst", cpu_rst, !exp_run);
      chk("busy", busy, load_active);
      if (imem_we) begin
        chk("write_spacing", since_wr >= 5, 1);
        since_wr = 0;
        chk("ready_in_write", byte_ready, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", imem_we, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("imem_addr", imem_addr, e.a);
          chk("imem_wdata", imem_wdata, e.d);
          log_a.push_back(imem_addr);
          log_d.push_back(imem_wdata);
          $display("write addr=0x%02h data=0x%08h expected addr=0x%02h data=0x%08h", imem_addr, imem_wdata, e.a, e.d);
          if (exp_q.size() == 0) begin
            load_active   = 0;
            exp_done_next = 1;
          end
        end
      end else begin
        chk("byte_ready", byte_ready, load_active);
      end
    end
  end

  task automatic do_reset(input int cycles);
    byte_valid = 1'b0;
    start      = 1'b0;
    rst        = 1'b0;
    exp_q.delete();
    load_active   = 0;
    exp_run       = 0;
    exp_done_next = 0;
    repeat (cycles) @(posedge clk);
    #3 rst = 1'b1;
  endtask

  task automatic idle_noise(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1 byte_valid = 1'($urandom);
      byte_data = 8'($urandom);
    end
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle between bytes, 2 random idle cycles.
  task automatic do_load(input int wc, input bq_t src, input int gap_mode,
                         input int abort_after, input bit start_noise);
    int  n;
    bq_t b;
    bit  r;
    int  tmo;
    n = (wc > 256) ? 256 : wc;
    b = src;
    while (b.size() < 4 * n) b.push_back(8'($urandom));
    for (int w = 0; w < n; w++)
      exp_q.push_back('{a: 8'(w), d: {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]}});
    $display("load start word_count=%0d effective=%0d gap_mode=%0d", wc, n, gap_mode);
    @(posedge clk);
    #1 start = 1'b1;
    word_count = 9'(wc);
    @(posedge clk);
    #1 start = 1'b0;
    if (n == 0) exp_done_next = 1;
    else begin
      load_active = 1;
      exp_run     = 0;
    end
    for (int k = 0; k < 4 * n; k++) begin
      if (k == abort_after) begin
        $display("reset asserted after %0d bytes", k);
        do_reset(3);
        return;
      end
      if (k > 0 && (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0))) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        repeat ((gap_mode == 1) ? 1 : $urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      byte_valid = 1'b1;
      byte_data  = b[k];
      start      = start_noise && ($urandom_range(0, 3) == 0);
      word_count = 9'($urandom);
      tmo = 0;
      do begin
        @(negedge clk);
        r = byte_ready;
        @(posedge clk);
        #1 start = 1'b0;
        tmo++;
      end while (!r && tmo < 50);
      byte_valid = 1'b0;
      if (!r) begin
        chk("byte_accept_timeout", r, 1);
        return;
      end
    end
    for (int t = 0; t < 30 && !exp_run; t++) @(posedge clk);
    chk("load_done", exp_run, 1);
    @(negedge clk);
  endtask

  bq_t empty_q;
  bq_t t2 = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  bq_t t5 = '{8'h11, 8'h22, 8'h33, 8'h44};
  bq_t t6 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    #100;
    @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    chk("init_cpu_rst", cpu_rst, 1);
    chk("init_byte_ready", byte_ready, 0);
    chk("init_imem_we", imem_we, 0);

    log_a.delete(); log_d.delete();
    do_load(2, t2, 0, -1, 0);
    chk("t2_writes", log_a.size(), 2);
    chk("t2_addr0", log_a[0], 8'h00);
    chk("t2_data0", log_d[0], 32'h00500013);
    chk("t2_addr1", log_a[1], 8'h01);
    chk("t2_data1", log_d[1], 32'h00100093);
    idle_noise(5);

    log_a.delete(); log_d.delete();
    do_load(2, t2, 1, -1, 0);
    chk("t3_writes", log_a.size(), 2);
    chk("t3_data0", log_d[0], 32'h00500013);
    chk("t3_data1", log_d[1], 32'h00100093);
    idle_noise(4);

    log_a.delete(); log_d.delete();
    do_load(0, empty_q, 0, -1, 0);
    idle_noise(3);
    chk("t4_zero_writes", log_a.size(), 0);
    do_load(300, empty_q, 0, -1, 0);
    chk("t4_sat_writes", log_a.size(), 256);
    chk("t4_first_addr", log_a[0], 8'h00);
    chk("t4_last_addr", log_a[255], 8'hFF);
    idle_noise(3);

    do_load(2, empty_q, 2, 6, 0);
    log_a.delete(); log_d.delete();
    do_load(1, t5, 0, -1, 0);
    chk("t5_writes", log_a.size(), 1);
    chk("t5_data", log_d[0], 32'h44332211);
    idle_noise(3);

    log_a.delete(); log_d.delete();
    do_load(1, t6, 2, -1, 1);
    chk("t6_writes", log_a.size(), 1);
    chk("t6_addr", log_a[0], 8'h00);
    chk("t6_data", log_d[0], 32'hDDCCBBAA);

    for (int i = 0; i < 10; i++) begin
      idle_noise($urandom_range(1, 6));
      do_load($urandom_range(0, 6), empty_q, $urandom_range(0, 2), -1, 1);
    end
    idle_noise(3);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
